piso_serializer: RTL
====================

# piso_serializer

Parallel-in, serial-out frame transmitter. It is the driving end of the team's serial bit-stream path and feeds the single-bit line that the shift-register chain receives. It accepts a WIDTH-bit word through a ready/load handshake. It then emits a framed bit sequence on `out`: start bit, data bits, optional even-parity bit, then stop bits. Each bit is held for a programmable number of clock cycles.

## Interface
- `WIDTH`, 8, data word width; legal range ≥ 1
- `MSB_FIRST`, 0, 0 = data sent LSB first, 1 = MSB first
- `CYCLES_PER_BIT`, 1, clock cycles each bit is held on `out`; legal range ≥ 1
- `PARITY_EN`, 0, 1 = insert even-parity bit after the data bits
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2

Ports:
- `clk`  input  1  single clock; all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `data_in`  input  WIDTH  word to transmit; sampled only on acceptance
- `load`  input  1  request to transmit `data_in`
- `ready`  output  1  block is idle and can accept a word
- `out`  output  1  serial line, registered; idle level 1
- `busy`  output  1  a frame is in progress (equals ~`ready` outside reset)
- `done`  output  1  one-cycle pulse marking the end of a frame

## Operation
- **Reset values:** state IDLE; `out`=1, `ready`=1, `busy`=0, `done`=0; counters cleared.
- **Acceptance:** a word is accepted on a rising edge where `load`=1 and `ready`=1.
  - At that edge the block captures `data_in` into the shift register.
  - Parity = XOR of all data bits, captured at the same edge.
  - State moves to START.
- `load` while `busy` is ignored; there is no queue and no error flag.
- `data_in` changes after acceptance have no effect on the frame.
- **States:**
  - IDLE: `out`=1; waits for acceptance.
  - START: `out`=0 for one bit time, then DATA.
  - DATA: WIDTH bits, shifted LSB- or MSB-first per `MSB_FIRST`. After the last bit, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: `out`=even parity for one bit time, then STOP.
  - STOP: `out`=1 for STOP_BITS bit times, then IDLE.
- **Bit timer:** one bit time = CYCLES_PER_BIT cycles.
  - Cycle counter counts 0..CYCLES_PER_BIT-1 and wraps.
  - Its wrap produces the bit tick that advances the bit counter and state.
- **Bit counter:** counts 0..WIDTH-1 in DATA and 0..STOP_BITS-1 in STOP; cleared on each state entry.
- **Counter widths:** max(1, clog2(WIDTH)) and max(1, clog2(CYCLES_PER_BIT)). No overflow is possible within the legal parameter ranges.
- **Reset mid-frame:** at the next edge `out`=1 and state IDLE; the frame is abandoned and `done` is not pulsed.
- **Simultaneous `rst` and `load`:** `rst` wins and the word is not accepted.

## Timing
- Frame length F = (1 + WIDTH + PARITY_EN + STOP_BITS) × CYCLES_PER_BIT cycles.
- Acceptance at edge N: `out`=0 (start bit) from edge N through edge N+CYCLES_PER_BIT.
- First data bit appears at edge N+CYCLES_PER_BIT.
- Final stop-bit cycle ends at edge N+F.
  - At that edge: `ready`=1, `busy`=0, `done`=1.
  - `done` returns to 0 at edge N+F+1.
- **Back-to-back frames:**
  - If `load`=1 in the cycle where `done`=1, the next word is accepted at edge N+F+1.
  - Minimum gap between frames is one idle cycle with `out`=1.
- `ready` and `busy` are registered; `ready` is never combinationally dependent on `load`.

## Structure
- Package `serial_pkg`:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constants: IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
  - The receiving side reuses this package.
- Sub-module `bit_timer`: parameter CYCLES_PER_BIT; inputs `clk`, `rst`, `run`; output `bit_tick`, a one-cycle pulse on counter wrap.
  - `run`=0 holds its counter at 0.
  - Top level asserts `run` in every state except IDLE.

## Test plan
- WIDTH=8, LSB first, CYCLES_PER_BIT=1, no parity, data 0x1D → `out` over 10 cycles: 0,1,0,1,1,1,0,0,0,1. `done` pulses at edge N+10.
- Same settings with MSB_FIRST=1, data 0x1D → `out`: 0,0,0,0,1,1,1,0,1,1.
- PARITY_EN=1, STOP_BITS=2, data 0x07 → `out`: 0,1,1,1,0,0,0,0,0,1(parity),1,1. Frame length 12.
- CYCLES_PER_BIT=3, data 0x01 → start bit low for 3 cycles, bit0 high for 3 cycles, F=30 cycles. A `load` pulse mid-frame is ignored and the frame is unchanged.
- `load` held high continuously with data 0xFF then 0x00 → two frames separated by exactly one idle cycle. `done` pulses once per frame.
- `rst` asserted during DATA bit 4 → `out`=1 and `ready`=1 at the next edge, no `done`. A new `load` two cycles later transmits a full frame correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-line definitions: frame states, line levels and counter sizing.
// Used by both the transmit serializer and the receive side.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-load handshake and serial line of the frame transmitter.
// Master drives the word and load request; slave (the serializer) returns status and line.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load,
        input  ready, out, busy, done
    );

    modport slave (
        input  data_in, load,
        output ready, out, busy, done
    );
endinterface

// File: rtl/piso_serializer_bit_timer.sv
// Bit-time divider: pulses bit_tick on the last cycle of each CYCLES_PER_BIT window.
// Zero latency from counter state to tick; run=0 parks the counter at 0.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);
    localparam int CYC_W = cnt_width(CYCLES_PER_BIT);

    logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             wrap;

    always_comb begin
        wrap      = run && (cyc_cnt_q == CYC_W'(CYCLES_PER_BIT - 1));
        cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        if (!run || wrap) begin
            cyc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign bit_tick = wrap;

endmodule

// File: rtl/piso_serializer.sv
// Frame transmitter: start bit, WIDTH data bits, optional even parity, STOP_BITS stop bits.
// Start bit appears the edge a word is accepted; ready is registered and low for the whole frame (no queue).
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter bit MSB_FIRST      = 1'b0,
    parameter int CYCLES_PER_BIT = 1,
    parameter bit PARITY_EN      = 1'b0,
    parameter int STOP_BITS      = 1
) (
    input  logic             clk,
    input  logic             rst,
    piso_serializer_if.slave bus
);
    localparam int BIT_CNT_W = cnt_width(WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic                   out_q, out_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timer_run;
    logic                   bit_tick;
    logic                   next_bit;
    logic [WIDTH-1:0]       shifted;

    assign timer_run = (state_q != IDLE);

    bit_timer #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (timer_run),
        .bit_tick (bit_tick)
    );

    // The bit leaving next always sits at the shift-out end; shifting consumes it.
    assign next_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shifted  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        out_d     = out_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                out_d = IDLE_LEVEL;
                if (bus.load && ready_q) begin
                    state_d   = START;
                    shift_d   = bus.data_in;
                    parity_d  = ^bus.data_in;
                    bit_cnt_d = '0;
                    out_d     = START_LEVEL;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    out_d     = next_bit;
                    shift_d   = shifted;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            out_d   = parity_q;
                        end else begin
                            state_d = STOP;
                            out_d   = STOP_LEVEL;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        out_d     = next_bit;
                        shift_d   = shifted;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    out_d     = STOP_LEVEL;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        out_d     = IDLE_LEVEL;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = IDLE_LEVEL;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            out_q     <= IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
